// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the transmit buffer and its FIFO.
package uart_pkg;

   localparam int unsigned UART_DBIT = 8;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } tx_buf_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous circular FIFO with occupancy count, sticky overflow and registered read data.
module uart_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DW = 8,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          ovf_clr
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   count_q;
   logic [DW-1:0] rd_data_q;
   logic          overflow_q;
   logic          do_wr, do_rd;

   // Full/empty come from the pre-cycle count, so a write while full is dropped even on a pop.
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign do_wr = wr_en && !full;
   assign do_rd = rd_en && !empty;

   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wp_q] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q       <= '0;
         rp_q       <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_wr) begin
            wp_q <= wp_q + 1'b1;
         end
         if (do_rd) begin
            rp_q      <= rp_q + 1'b1;
            rd_data_q <= mem[rp_q];
         end
         if (do_wr && !do_rd) begin
            count_q <= count_q + 1'b1;
         end else if (do_rd && !do_wr) begin
            count_q <= count_q - 1'b1;
         end
         // Set-dominant: a dropped write wins over a simultaneous clear.
         if (wr_en && full) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmit buffer: queues host bytes and launches them one frame at a time.
module uart_tx_buf
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [UART_DBIT-1:0] wr_data,
   output logic                 full,
   output logic                 empty,
   output logic [AW:0]          count,
   output logic                 overflow,
   input  logic                 ovf_clr,
   output logic                 tx_start,
   output logic [UART_DBIT-1:0] tx_dout,
   input  logic                 tx_done_tick,
   output logic                 tx_busy
);

   tx_buf_state_t state_q;
   logic          tx_start_q;
   logic          pop;

   // The FIFO read register doubles as the tx_dout register; it only loads on a pop.
   assign pop = (state_q == IDLE) && !empty;

   uart_fifo #(
      .DEPTH(DEPTH),
      .DW   (UART_DBIT)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (tx_dout),
      .full    (full),
      .empty   (empty),
      .count   (count),
      .overflow(overflow),
      .ovf_clr (ovf_clr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!empty) begin
                  state_q    <= LAUNCH;
                  tx_start_q <= 1'b1;
               end
            end
            LAUNCH: state_q <= WAIT;
            WAIT: begin
               if (tx_done_tick) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_start = tx_start_q;
   assign tx_busy  = (state_q != IDLE);

endmodule
